acs_unit: RTL

//   Add-compare-select stage of the K=3, rate-1/2 hard-decision Viterbi decoder (generators 7,5 octal).

---
 rtl/acs_unit_if.sv | 23 ++
 rtl/acs_unit.sv | 120 ++++++++++++
 2 files changed

// File: rtl/acs_unit_if.sv
// Symbol-in / decision-out bundle of the Viterbi add-compare-select stage.
// The master drives received symbols; the slave (acs_unit) returns the
// survivor decisions and traceback start state for path memory.
interface acs_unit_if;
  logic [1:0] sym;
  logic       sym_valid;
  logic       sym_first;
  logic       sym_erase;
  logic [3:0] ACS;
  logic [1:0] control;
  logic       dec_valid;
  logic       norm;

  modport master (
    output sym, sym_valid, sym_first, sym_erase,
    input  ACS, control, dec_valid, norm
  );

  modport slave (
    input  sym, sym_valid, sym_first, sym_erase,
    output ACS, control, dec_valid, norm
  );
endinterface

// File: rtl/acs_unit.sv
// Add-compare-select for the K=3, rate-1/2 hard-decision Viterbi decoder
// (generators 7,5 octal). One symbol per accepted cycle; all outputs are
// registered with one cycle of latency.
// Optional feature macro: VIT_ERASURE_EN -- when defined, an erased symbol
// zeroes every branch metric; when undefined, sym_erase is ignored.
module acs_unit #(
  parameter int MW     = 4,
  parameter int INIT_M = 3
) (
  input logic       clk,
  input logic       reset,
  acs_unit_if.slave bus
);

  typedef logic [MW-1:0] metric_t;

  metric_t [3:0] pm_q;
  metric_t [3:0] pm_init;
  metric_t [3:0] pm_base;
  metric_t [3:0] cand0;
  metric_t [3:0] cand1;
  metric_t [3:0] pm_sel;
  metric_t [3:0] pm_new;
  metric_t       min_val;
  logic    [3:0] dec;
  logic    [3:0] msb;
  logic          all_hi;
  logic    [1:0] min_idx;
  logic          erase;

  logic    [3:0] acs_q;
  logic    [1:0] control_q;
  logic          dec_valid_q;
  logic          norm_q;

`ifdef VIT_ERASURE_EN
  assign erase = bus.sym_erase;
`else
  assign erase = 1'b0;
`endif

  // Frame start: state 0 is the known encoder start, others are penalised.
  assign pm_init = {metric_t'(INIT_M), metric_t'(INIT_M), metric_t'(INIT_M), metric_t'(0)};

  // Hamming distance between the received symbol and the encoder output
  // on the branch from predecessor {n[0], p_lsb} into next state n.
  function automatic metric_t branch_metric(input logic [1:0] n, input logic p_lsb,
                                            input logic [1:0] s, input logic er);
    logic       u;
    logic [1:0] p;
    logic [1:0] x;
    u = n[1];
    p = {n[0], p_lsb};
    x = s ^ {u ^ p[1] ^ p[0], u ^ p[0]};
    return er ? metric_t'(0) : metric_t'(x[1]) + metric_t'(x[0]);
  endfunction

  // Add and compare for each next state; ties keep the even predecessor.
  always_comb begin
    pm_base = bus.sym_first ? pm_init : pm_q;
    cand0   = '0;
    cand1   = '0;
    dec     = '0;
    pm_sel  = '0;
    msb     = '0;
    for (int n = 0; n < 4; n++) begin
      cand0[n]  = pm_base[{n[0], 1'b0}] + branch_metric(2'(n), 1'b0, bus.sym, erase);
      cand1[n]  = pm_base[{n[0], 1'b1}] + branch_metric(2'(n), 1'b1, bus.sym, erase);
      dec[n]    = cand1[n] < cand0[n];
      pm_sel[n] = dec[n] ? cand1[n] : cand0[n];
      msb[n]    = pm_sel[n][MW-1];
    end
  end

  // Normalise by dropping the top bit once every metric has it set, then
  // pick the minimum, lowest index winning ties.
  always_comb begin
    all_hi = &msb;
    pm_new = pm_sel;
    if (all_hi) begin
      for (int n = 0; n < 4; n++) begin
        pm_new[n][MW-1] = 1'b0;
      end
    end
    min_idx = 2'd0;
    min_val = pm_new[0];
    for (int n = 1; n < 4; n++) begin
      if (pm_new[n] < min_val) begin
        min_val = pm_new[n];
        min_idx = 2'(n);
      end
    end
  end

  // Register metrics and decisions on accepted symbols; reset wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      pm_q        <= pm_init;
      acs_q       <= '0;
      control_q   <= '0;
      dec_valid_q <= 1'b0;
      norm_q      <= 1'b0;
    end else if (bus.sym_valid) begin
      pm_q        <= pm_new;
      acs_q       <= dec;
      control_q   <= min_idx;
      dec_valid_q <= 1'b1;
      norm_q      <= all_hi;
    end else begin
      dec_valid_q <= 1'b0;
      norm_q      <= 1'b0;
    end
  end

  assign bus.ACS       = acs_q;
  assign bus.control   = control_q;
  assign bus.dec_valid = dec_valid_q;
  assign bus.norm      = norm_q;

endmodule
